clk_freq_monitor: RTL and testbench
===================================

# clk_freq_monitor

Single-clock frequency monitor for clocks generated by the on-board PLL. A PLL output, or a divided copy of it, enters as a plain data signal; the block counts its rising edges over a fixed gate window of `sys_clk` cycles and reports the count each window. It also flags whether the count is inside the configured limits and asserts `locked` after a run of consecutive good windows. It is the checking end of the PLL path, used in hardware bring-up and as a self-test in simulation benches.

## Interface
Parameters:
- `GATE_CYCLES`, 50000: window length in `sys_clk` cycles (1 ms at 50 MHz); must be ≥ 4.
- `CNT_W`, 16: width of the edge counter and of `edge_count`.
- `MIN_CNT`, 0: lower in-range limit, inclusive.
- `MAX_CNT`, 65535: upper in-range limit, inclusive; must be ≥ `MIN_CNT`.
- `GOOD_WINDOWS`, 4: number of consecutive in-range windows required to assert `locked`; must be ≥ 1.

Ports:
- `sys_clk`, in, 1: the only clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `en`, in, 1: measurement enable.
- `sig_in`, in, 1: signal under test, asynchronous to `sys_clk`. Its frequency must be below `sys_clk`/2, and each level must last ≥ 2 `sys_clk` cycles.
- `edge_count`, out, CNT_W: rising-edge count of the last completed window.
- `count_valid`, out, 1: one-cycle pulse when `edge_count` updates.
- `in_range`, out, 1: the last window's count satisfies `MIN_CNT` ≤ count ≤ `MAX_CNT` and did not overflow.
- `overflow`, out, 1: the last window's counter saturated.
- `locked`, out, 1: `GOOD_WINDOWS` consecutive in-range windows have been seen.

## Operation
- Input path: 2-flop synchronizer, then a third flop for the rising-edge detect. An edge pulse (`edge_p`) is produced when the delayed sample is 0 and the synchronized sample is 1.
- FSM states:
  - `IDLE`: window counter and edge counter held at 0.
  - `MEASURE`: gate counter runs from 0 to `GATE_CYCLES`-1; edge counter increments on each `edge_p`.
  - `REPORT`: exists for one cycle only; results are latched.
- Transitions:
  - `IDLE`→`MEASURE` when `en` is 1.
  - `MEASURE`→`REPORT` on the gate terminal count.
  - `REPORT`→`MEASURE` if `en` is 1, else `IDLE`.
  - Any state→`IDLE` when `en` is 0.
- Window boundaries: an `edge_p` on the terminal `MEASURE` cycle counts in the ending window. An `edge_p` during the `REPORT` cycle counts in the next window, whose edge counter starts at 1 instead of 0. No edges are lost between back-to-back windows.
- Saturation: the edge counter stops at 2^CNT_W−1 and sets a window-local overflow flag. At `REPORT`, `overflow` takes that flag and the flag clears for the next window.
- Lock tracking: a good-window counter saturates at `GOOD_WINDOWS`.
  - On an in-range `REPORT`, it increments.
  - On an out-of-range `REPORT`, it resets to 0.
  - `locked` = (counter == `GOOD_WINDOWS`).
- `en` deasserted mid-window: the partial window is discarded with no `count_valid`. `locked` and the good-window counter clear. `edge_count`, `in_range` and `overflow` hold their last values.

## Timing
- Reset: every output is 0; FSM is in `IDLE`; synchronizer flops are 0.
  - A `sig_in` that is already high at reset release does not produce an edge.
  - `rst` mid-window aborts the window, and the next window starts only after `en` is sampled high.
- `sig_in` to `edge_p` latency: 3 `sys_clk` cycles.
- First window: `en` sampled high at cycle t puts the FSM in `MEASURE` at t+1, and `REPORT` occurs at t+1+`GATE_CYCLES`.
- Window period when `en` is held high: `GATE_CYCLES`+1 cycles between `count_valid` pulses.
- Result latency: `edge_count`, `in_range`, `overflow` and `locked` are all registered and update in the same cycle as `count_valid`, i.e. one cycle after the terminal `MEASURE` cycle.
- The range compare is done on the full CNT_W-bit unsigned value.

## Structure
- Shared package `clk_mon_pkg`:
  - FSM state encoding (`IDLE`, `MEASURE`, `REPORT`).
  - A clog2-based width function used to size the gate counter from `GATE_CYCLES` and the good-window counter from `GOOD_WINDOWS`.
- Sub-module `sync_edge_det`: synchronizer plus rising-edge detector, with ports `sys_clk`, `rst`, `d_async`, `rise_p`. It is reusable elsewhere.
- The top level holds the FSM, the counters, the compare logic and the lock tracker.

## Test plan
Setup for all scenarios unless stated: 50 MHz `sys_clk`, `GATE_CYCLES`=1000, `MIN_CNT`=45, `MAX_CNT`=55, `GOOD_WINDOWS`=4.
- **Nominal lock:** `sig_in` period 20 cycles, `en`=1 → every `count_valid` shows `edge_count`=50 and `in_range`=1; `locked` rises with the 4th `count_valid`; `count_valid` spacing is 1001 cycles.
- **Limit boundaries:** edge counts of 44, 45, 55 and 56 per window → `in_range` = 0, 1, 1, 0 respectively; `locked` clears on the 56 window.
- **Dead clock:** `sig_in` held at 0 after lock → next window reports `edge_count`=0, `in_range`=0, and `locked` drops in the `count_valid` cycle.
- **Saturation:** `CNT_W`=8, `GATE_CYCLES`=2000, `sig_in` period 4 → `edge_count`=255, `overflow`=1, `in_range`=0.
- **Abort:** `en` dropped at cycle 500 of a window → no `count_valid`, `locked`=0, last `edge_count` held. Re-enable → `count_valid` arrives 1001 cycles after `en` is sampled high.
- **Reset mid-window:** `rst` pulsed with `sig_in` high → all outputs read 0 the next cycle, and the first new window counts exactly 50 edges.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared types and sizing helpers for the clock frequency monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus a third flop for rising-edge detection.
module sync_edge_det (
  input  logic sys_clk,
  input  logic rst,
  input  logic d_async,
  output logic rise_p
);

  logic       s1_q;
  logic       s2_q;
  logic       s3_q;
  logic [1:0] prime_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      prime_q <= 2'd0;
    end else begin
      s1_q <= d_async;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
    end
  end

  // Edges are suppressed until s3 holds a real sample, so an input that is
  // already high when reset releases is not mistaken for a rising edge.
  assign rise_p = (prime_q == 2'd3) & s2_q & ~s3_q;

endmodule

// File: rtl/clk_freq_monitor.sv
// Counts rising edges of sig_in over fixed gate windows, range-checks each count
// and tracks lock over consecutive good windows.
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int GATE_CYCLES  = 50000,
  parameter int CNT_W        = 16,
  parameter int MIN_CNT      = 0,
  parameter int MAX_CNT      = 65535,
  parameter int GOOD_WINDOWS = 4
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic             in_range,
  output logic             overflow,
  output logic             locked,
  output state_t           dbg_state
);

  localparam int                GATE_W    = cnt_width(GATE_CYCLES - 1);
  localparam int                GOOD_W    = cnt_width(GOOD_WINDOWS);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(GOOD_WINDOWS);
  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;

  // count_valid is a one-cycle strobe with no back-pressure: edge_count,
  // in_range, overflow and locked are stable and qualified while it is high.

  state_t              state_q;
  state_t              state_d;
  logic [GATE_W-1:0]   gate_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_q;
  logic [GOOD_W-1:0]   good_q;
  logic                edge_p;
  logic                gate_done;
  logic [CNT_W-1:0]    cnt_inc;
  logic                ovf_inc;
  int                  cnt_int;
  logic                win_good;

  sync_edge_det u_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .d_async (sig_in),
    .rise_p  (edge_p)
  );

  assign gate_done = (state_q == MEASURE) && (gate_q == GATE_LAST);

  // Count including the current edge, so the terminal cycle's edge is kept.
  always_comb begin
    cnt_inc = cnt_q;
    ovf_inc = ovf_q;
    if (edge_p) begin
      if (cnt_q == CNT_SAT) ovf_inc = 1'b1;
      else                  cnt_inc = cnt_q + CNT_W'(1);
    end
  end

  assign cnt_int  = int'(cnt_inc);
  assign win_good = !ovf_inc && (cnt_int >= MIN_CNT) && (cnt_int <= MAX_CNT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = MEASURE;
      MEASURE: begin
        if (!en)            state_d = IDLE;
        else if (gate_done) state_d = REPORT;
      end
      REPORT:  state_d = en ? MEASURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gate_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      good_q      <= '0;
      edge_count  <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_valid <= 1'b0;
      case (state_q)
        MEASURE: begin
          gate_q <= gate_q + GATE_W'(1);
          cnt_q  <= cnt_inc;
          ovf_q  <= ovf_inc;
          if (en && gate_done) begin
            edge_count  <= cnt_inc;
            overflow    <= ovf_inc;
            in_range    <= win_good;
            count_valid <= 1'b1;
            if (!win_good)               good_q <= '0;
            else if (good_q != GOOD_MAX) good_q <= good_q + GOOD_W'(1);
            gate_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
          end
        end
        // An edge seen while reporting opens the next window's count.
        REPORT: begin
          gate_q <= '0;
          cnt_q  <= {{(CNT_W-1){1'b0}}, edge_p};
          ovf_q  <= 1'b0;
        end
        default: begin
          gate_q <= '0;
          cnt_q  <= '0;
          ovf_q  <= 1'b0;
        end
      endcase
      if (!en) begin
        gate_q <= '0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
        good_q <= '0;
      end
    end
  end

  assign locked    = (good_q == GOOD_MAX);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Randomized scoreboard bench for clk_freq_monitor: a sample-history model
// predicts each window's report, a monitor compares on count_valid.
module tb_clk_freq_monitor;
  import clk_mon_pkg::*;

  localparam int G       = 1000;
  localparam int CW      = 16;
  localparam int MINC    = 45;
  localparam int MAXC    = 55;
  localparam int GW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int SAT_G   = 2000;
  localparam int SAT_W   = 8;
  localparam int SAT_EXP = (SAT_G / 4 > 255) ? 255 : SAT_G / 4;
  localparam int HIST_N  = 60000;
  localparam int EXP_W   = 32 + CW + 3;

  localparam int SIG_LOW   = 0;
  localparam int SIG_PER   = 1;
  localparam int SIG_BURST = 2;

  // ---------------- clock / reset / DUT ----------------
  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          sig_in = 1'b0;
  logic [CW-1:0] edge_count;
  logic          count_valid, in_range, overflow, locked;
  state_t        dbg_state;

  logic             rst_sat = 1'b1;
  logic             en_sat = 1'b0;
  logic             sig_sat = 1'b0;
  logic [SAT_W-1:0] sat_count;
  logic             sat_valid, sat_rng, sat_ovf, sat_locked;
  state_t           sat_state;

  always #10 sys_clk = ~sys_clk;

  clk_freq_monitor #(
    .GATE_CYCLES(G), .CNT_W(CW), .MIN_CNT(MINC), .MAX_CNT(MAXC), .GOOD_WINDOWS(GW)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .en(en), .sig_in(sig_in),
    .edge_count(edge_count), .count_valid(count_valid), .in_range(in_range),
    .overflow(overflow), .locked(locked), .dbg_state(dbg_state)
  );

  clk_freq_monitor #(
    .GATE_CYCLES(SAT_G), .CNT_W(SAT_W), .MIN_CNT(MINC), .MAX_CNT(MAXC), .GOOD_WINDOWS(GW)
  ) dut_sat (
    .sys_clk(sys_clk), .rst(rst_sat), .en(en_sat), .sig_in(sig_sat),
    .edge_count(sat_count), .count_valid(sat_valid), .in_range(sat_rng),
    .overflow(sat_ovf), .locked(sat_locked), .dbg_state(sat_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_i);
    end
  endtask

  int cyc_i = 0;
  bit sig_hist [HIST_N];

  always @(posedge sys_clk) begin
    cyc_i = cyc_i + 1;
    if (cyc_i < HIST_N) sig_hist[cyc_i] = sig_in;
  end

  // ---------------- stimulus generator ----------------
  int sig_mode = SIG_LOW;
  int hp = 10;
  int per_ph = 0;
  int burst_n = 0;
  int t_base = 0;
  int win_k = 0;
  int sig_off;

  always @(negedge sys_clk) begin
    case (sig_mode)
      SIG_PER: sig_in = ((cyc_i - per_ph) % (2 * hp)) < hp;
      SIG_BURST: begin
        sig_off = (cyc_i - t_base) % (G + 1);
        sig_in  = (sig_off >= 60) && (sig_off < 60 + 8 * burst_n) && (((sig_off - 60) % 8) < 4);
      end
      default: sig_in = 1'b0;
    endcase
    sig_sat = cyc_i[1];
  end

  task automatic set_per(input int h);
    hp       = h;
    per_ph   = cyc_i;
    sig_mode = SIG_PER;
  endtask

  task automatic set_burst(input int n);
    burst_n  = n;
    sig_mode = SIG_BURST;
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [EXP_W-1:0] exp_q [$];
  int good_run = 0;
  int last_cnt = 0;
  bit last_rng = 1'b0;
  int last_e = 0;

  task automatic start_en();
    @(negedge sys_clk);
    en     = 1'b1;
    t_base = cyc_i + 1;
    win_k  = 0;
  endtask

  // A rise sampled at posedge j is counted at posedge j+2; window k closes at
  // posedge t+G+k(G+1) and owns every counting posedge since the previous close.
  task automatic next_window();
    int s, e, n;
    bit ov, rng, lck;
    e = t_base + G + win_k * (G + 1);
    s = (win_k == 0) ? t_base + 1 : e - G;
    while (cyc_i < e - 1) @(negedge sys_clk);
    n = 0;
    for (int c = s; c <= e; c++)
      if (c - 2 >= 1 && sig_hist[c-2] && !sig_hist[c-3]) n++;
    ov = (n > CNT_MAX);
    if (ov) n = CNT_MAX;
    rng = !ov && (n >= MINC) && (n <= MAXC);
    good_run = rng ? good_run + 1 : 0;
    lck = (good_run >= GW);
    exp_q.push_back({e, n[CW-1:0], ov, rng, lck});
    last_cnt = n;
    last_rng = rng;
    last_e   = e;
    win_k++;
  endtask

  logic [EXP_W-1:0] mon_item;

  always @(negedge sys_clk) begin
    if (!rst && count_valid) begin
      chk("valid_has_expect", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_item = exp_q.pop_front();
        chk("valid_cycle", cyc_i, longint'(mon_item[EXP_W-1 -: 32]));
        chk("edge_count", edge_count, longint'(mon_item[CW+2:3]));
        chk("ovf_range_lock", {overflow, in_range, locked}, longint'(mon_item[2:0]));
      end
    end
  end

  int sat_last = 0;
  int sat_n = 0;

  always @(negedge sys_clk) begin
    if (!rst_sat && sat_valid) begin
      chk("sat_edge_count", sat_count, SAT_EXP);
      chk("sat_overflow", sat_ovf, 1);
      chk("sat_in_range", sat_rng, 0);
      chk("sat_locked", sat_locked, 0);
      if (sat_last > 0) chk("sat_spacing", cyc_i - sat_last, SAT_G + 1);
      sat_last = cyc_i;
      sat_n++;
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_edge_count"}, edge_count, 0);
    chk({tag, "_count_valid"}, count_valid, 0);
    chk({tag, "_in_range"}, in_range, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_state"}, longint'(dbg_state), longint'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int bursts [4];
    int found;
    bursts = '{45, 55, 56, 44};

    repeat (3) @(negedge sys_clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    rst_sat = 1'b0;
    en_sat = 1'b1;
    repeat (5) @(negedge sys_clk);

    // nominal lock
    set_per(10);
    start_en();
    repeat (5) next_window();

    // limit boundaries
    for (int i = 0; i < 4; i++) begin
      set_burst(bursts[i]);
      next_window();
    end

    // randomized windows
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) set_per($urandom_range(8, 14));
      else                           set_burst($urandom_range(40, 60));
      next_window();
    end

    // relock, then dead clock
    set_per(10);
    repeat (4) next_window();
    sig_mode = SIG_LOW;
    repeat (2) next_window();

    // abort mid-window and re-enable
    set_per(10);
    repeat (2) next_window();
    while (cyc_i < last_e + 501) @(negedge sys_clk);
    en = 1'b0;
    good_run = 0;
    repeat (20) @(negedge sys_clk);
    chk("abort_locked", locked, 0);
    chk("abort_edge_count_held", edge_count, last_cnt);
    chk("abort_in_range_held", in_range, last_rng);
    chk("abort_state", longint'(dbg_state), longint'(IDLE));
    repeat (700) @(negedge sys_clk);
    start_en();
    repeat (2) next_window();

    // reset mid-window while sig_in is high
    repeat (300) @(negedge sys_clk);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge sys_clk);
      if (sig_hist[cyc_i] && !sig_hist[cyc_i-1]) found = 1;
    end
    repeat (3) @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    t_base = cyc_i + 1;
    win_k = 0;
    good_run = 0;
    repeat (2) next_window();

    repeat (10) @(negedge sys_clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("sat_windows_seen", longint'(sat_n >= 2), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc_i);
    $fatal(1, "watchdog expired");
  end

endmodule
